// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scanner_if
//  Purpose  : Bundles the register-select controls, register file input and
//             display outputs of seven_seg_scanner.
//  Signals  : sel        manual register select
//             regs_flat  register file, reg i at [i*DATA_W +: DATA_W]
//             mode_auto  auto-cycle registers
//             hold       freeze snapshot and index
//             blank_lz   blank leading zero digits
//             cur_idx    index of register held in the snapshot
//             an         multiplexed digit enables, active-low one-hot
//             seg        segments of the enabled digit, active-low
//             displ      static segments, digit k at [7k +: 7]
//  Modports : master (drives controls), slave (the scanner)
//  Revision : 1.0  initial release
// ============================================================================
interface seven_seg_scanner_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) ();
  localparam int c_digits = DATA_W / 4;

  logic [SEL_W-1:0]           sel;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       mode_auto;
  logic                       hold;
  logic                       blank_lz;
  logic [SEL_W-1:0]           cur_idx;
  logic [c_digits-1:0]        an;
  logic [6:0]                 seg;
  logic [7*c_digits-1:0]      displ;

  modport master (
    output sel, regs_flat, mode_auto, hold, blank_lz,
    input  cur_idx, an, seg, displ
  );

  modport slave (
    input  sel, regs_flat, mode_auto, hold, blank_lz,
    output cur_idx, an, seg, displ
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scanner
//  Purpose  : Register-file display unit. Picks one register (manual select
//             or auto-cycling), snapshots it and shows it as hex both on a
//             time-multiplexed display (an/seg) and on static per-digit
//             segment outputs (displ). Supports hold/freeze and leading-zero
//             blanking. Segments are active-low, bit0 = segment a.
//  Ports    : clk    system clock, rising edge
//             reset  asynchronous, active-high
//             bus    seven_seg_scanner_if.slave (controls in, display out)
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 1000,
  parameter int AUTO_DIV = 50000000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  seven_seg_scanner_if.slave bus
);
  localparam int         c_digits   = DATA_W / 4;
  localparam int         c_ptr_w    = (c_digits > 1) ? $clog2(c_digits) : 1;
  localparam int         c_scan_w   = $clog2(SCAN_DIV);
  localparam int         c_auto_w   = $clog2(AUTO_DIV);
  localparam int         c_slots    = 2 ** SEL_W;
  localparam logic [6:0] c_blank    = 7'h7F;
  localparam logic [6:0] c_zero_seg = 7'h40;

  function automatic logic [6:0] f_hex_enc(input logic [3:0] nib);
    logic [6:0] v;
    case (nib)
      4'h0: v = 7'h40;  4'h1: v = 7'h79;  4'h2: v = 7'h24;  4'h3: v = 7'h30;
      4'h4: v = 7'h19;  4'h5: v = 7'h12;  4'h6: v = 7'h02;  4'h7: v = 7'h78;
      4'h8: v = 7'h00;  4'h9: v = 7'h10;  4'hA: v = 7'h08;  4'hB: v = 7'h03;
      4'hC: v = 7'h46;  4'hD: v = 7'h21;  4'hE: v = 7'h06;  default: v = 7'h0E;
    endcase
    return v;
  endfunction

  logic [SEL_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_snap;
  logic [c_auto_w-1:0]   r_auto_cnt;
  logic [c_scan_w-1:0]   r_scan_cnt;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [c_digits-1:0]   r_an;
  logic [6:0]            r_seg;
  logic [7*c_digits-1:0] r_displ;

  // Every encodable index gets a slot; slots past NUM_REGS read as zero so an
  // out-of-range select snapshots 0 without a separate range check.
  logic [DATA_W-1:0] w_regs [c_slots];
  generate
    for (genvar i = 0; i < c_slots; i++) begin : g_reg_slot
      if (i < NUM_REGS) begin : g_real
        assign w_regs[i] = bus.regs_flat[i*DATA_W +: DATA_W];
      end else begin : g_empty
        assign w_regs[i] = '0;
      end
    end
  endgenerate

  // Per-digit segment pattern of the snapshot, including leading-zero blanking.
  // A digit is blank when it and every more significant nibble are zero; the
  // least significant digit always shows.
  logic [6:0]            w_digit_seg [c_digits];
  logic [7*c_digits-1:0] w_displ;
  generate
    for (genvar k = 0; k < c_digits; k++) begin : g_digit
      logic w_blank;
      if (k == 0) begin : g_lsd
        assign w_blank = 1'b0;
      end else begin : g_upper
        assign w_blank = bus.blank_lz && (r_snap[DATA_W-1:4*k] == '0);
      end
      assign w_digit_seg[k]    = w_blank ? c_blank : f_hex_enc(r_snap[4*k +: 4]);
      assign w_displ[7*k +: 7] = w_digit_seg[k];
    end
  endgenerate

  // Auto-cycling only counts while it is actually allowed to step.
  logic             w_auto_run;
  logic             w_auto_term;
  logic [SEL_W-1:0] w_idx_inc;
  logic [SEL_W-1:0] w_idx_next;

  assign w_auto_run  = bus.mode_auto && !bus.hold;
  assign w_auto_term = w_auto_run && (r_auto_cnt == c_auto_w'(AUTO_DIV - 1));
  assign w_idx_inc   = (r_idx == SEL_W'(NUM_REGS - 1)) ? '0 : r_idx + SEL_W'(1);

  always_comb begin
    w_idx_next = r_idx;
    if (!bus.hold) begin
      if (!bus.mode_auto) begin
        w_idx_next = bus.sel;
      end else if (w_auto_term) begin
        w_idx_next = w_idx_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto_cnt <= '0;
      r_idx      <= '0;
      r_snap     <= '0;
    end else begin
      if (!w_auto_run || w_auto_term) begin
        r_auto_cnt <= '0;
      end else begin
        r_auto_cnt <= r_auto_cnt + c_auto_w'(1);
      end
      r_idx <= w_idx_next;
      // Snapshot follows the index chosen on this same edge.
      if (!bus.hold) begin
        r_snap <= w_regs[w_idx_next];
      end
    end
  end

  // Digit scan runs independently of hold/mode so the display never freezes.
  logic w_scan_term;
  assign w_scan_term = (r_scan_cnt == c_scan_w'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_ptr      <= '0;
      r_an       <= '1;
      r_seg      <= c_blank;
      r_displ    <= {c_digits{c_zero_seg}};
    end else begin
      if (w_scan_term) begin
        r_scan_cnt <= '0;
        r_ptr      <= (r_ptr == c_ptr_w'(c_digits - 1)) ? '0 : r_ptr + c_ptr_w'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
      end
      r_an    <= ~(c_digits'(1) << r_ptr);
      r_seg   <= w_digit_seg[r_ptr];
      r_displ <= w_displ;
    end
  end

  assign bus.cur_idx = r_idx;
  assign bus.an      = r_an;
  assign bus.seg     = r_seg;
  assign bus.displ   = r_displ;
endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scanner
//  Purpose  : Self-checking bench for seven_seg_scanner. Directed scenarios
//             plus randomized control/register traffic compared every cycle
//             against a behavioural model of the display unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 6;
  localparam int SEL_W    = 3;
  localparam int SCAN_DIV = 4;
  localparam int AUTO_DIV = 3;
  localparam int DIGITS   = DATA_W / 4;

  logic clk;
  logic reset;

  seven_seg_scanner_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) bus ();

  seven_seg_scanner #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
    .SCAN_DIV(SCAN_DIV), .AUTO_DIV(AUTO_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Lit segments of each hex glyph, by segment letter.
  string c_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] enc(input int n);
    logic [6:0] r = 7'h7F;
    string s = c_lit[n];
    for (int i = 0; i < s.len(); i++) r[s[i] - 8'd97] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] digit_view(input logic [15:0] v, input bit blz, input int k);
    int rest = int'(v) >> (4 * k);
    if (blz && k > 0 && rest == 0) return 7'h7F;
    return enc(rest % 16);
  endfunction

  // Reference model state
  logic [15:0] regs [NUM_REGS];
  int          m_idx;
  logic [15:0] m_snap;
  int          m_auto;
  int          m_edges;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [27:0] m_displ;

  task automatic model_reset();
    m_idx = 0; m_snap = 16'h0; m_auto = 0; m_edges = 0;
    m_an = 4'hF; m_seg = 7'h7F;
    for (int k = 0; k < DIGITS; k++) m_displ[7*k +: 7] = enc(0);
  endtask

  task automatic model_step();
    int nidx = m_idx;
    int ptr  = (m_edges / SCAN_DIV) % DIGITS;
    m_an  = ~(4'b0001 << ptr);
    m_seg = digit_view(m_snap, bus.blank_lz, ptr);
    for (int k = 0; k < DIGITS; k++) m_displ[7*k +: 7] = digit_view(m_snap, bus.blank_lz, k);
    m_edges++;
    if (bus.hold) begin
      m_auto = 0;
    end else if (!bus.mode_auto) begin
      m_auto = 0;
      nidx   = int'(bus.sel);
    end else begin
      m_auto++;
      if (m_auto == AUTO_DIV) begin
        m_auto = 0;
        nidx   = (m_idx == NUM_REGS - 1) ? 0 : (m_idx + 1) % (1 << SEL_W);
      end
    end
    if (!bus.hold) m_snap = (nidx < NUM_REGS) ? regs[nidx] : 16'h0;
    m_idx = nidx;
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    regs[i] = v;
    bus.regs_flat[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_cur_idx"}, 64'(bus.cur_idx), 64'(m_idx));
    check({tag, "_an"},      64'(bus.an),      64'(m_an));
    check({tag, "_seg"},     64'(bus.seg),     64'(m_seg));
    check({tag, "_displ"},   64'(bus.displ),   64'(m_displ));
  endtask

  // One clock: model advances at the edge, outputs compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic randomize_inputs();
    logic [15:0] v;
    bus.sel = SEL_W'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) bus.mode_auto = ~bus.mode_auto;
    if ($urandom_range(0, 9) == 0) bus.hold = ~bus.hold;
    if ($urandom_range(0, 5) == 0) bus.blank_lz = ~bus.blank_lz;
    if ($urandom_range(0, 3) == 0) begin
      v = 16'($urandom & (32'hFFFF >> (4 * $urandom_range(0, 4))));
      set_reg($urandom_range(0, NUM_REGS - 1), v);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.sel = '0; bus.mode_auto = 1'b0; bus.hold = 1'b0; bus.blank_lz = 1'b0;
    bus.regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h0;
    model_reset();
    #2;
    check_outputs("reset");
    check("reset_an_const", 64'(bus.an), 64'(4'hF));
    @(negedge clk);
    reset = 1'b0;

    // Manual select and static display of a known register
    set_reg(2, 16'h1A2F);
    bus.sel = 3'd2;
    cycle("t1a");
    check("t1_idx", 64'(bus.cur_idx), 64'd2);
    cycle("t1b");
    check("t1_displ", 64'(bus.displ), 64'({7'h79, 7'h08, 7'h24, 7'h0E}));

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    set_reg(2, 16'h0040);
    cycle("t4a"); cycle("t4b");
    check("t4_displ_0040", 64'(bus.displ), 64'({7'h7F, 7'h7F, 7'h19, 7'h40}));
    set_reg(2, 16'h0000);
    cycle("t4c"); cycle("t4d");
    check("t4_displ_zero", 64'(bus.displ), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Multiplexed scan across several full rotations
    bus.blank_lz = 1'b0;
    set_reg(2, 16'h1A2F);
    repeat (20) cycle("t2");

    // Auto-cycling with wrap, then hold freezes index and snapshot
    bus.sel = 3'd4;
    cycle("t3a");
    bus.mode_auto = 1'b1;
    repeat (9) cycle("t3b");
    check("t3_idx_wrap", 64'(bus.cur_idx), 64'd1);
    bus.hold = 1'b1;
    set_reg(1, 16'hBEEF);
    repeat (6) cycle("t3c");
    check("t3_hold_idx", 64'(bus.cur_idx), 64'd1);

    // Out-of-range select, then auto from the invalid index
    bus.hold = 1'b0; bus.mode_auto = 1'b0; bus.sel = 3'd7;
    cycle("t5a"); cycle("t5b");
    check("t5_idx", 64'(bus.cur_idx), 64'd7);
    check("t5_displ", 64'(bus.displ), 64'({4{7'h40}}));
    bus.mode_auto = 1'b1;
    repeat (7) cycle("t5c");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      randomize_inputs();
      cycle("rnd");
    end

    // Asynchronous reset in the middle of scanning/auto-cycling
    bus.mode_auto = 1'b1; bus.hold = 1'b0;
    repeat (5) cycle("t6a");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("t6_an",      64'(bus.an),      64'(4'hF));
    check("t6_seg",     64'(bus.seg),     64'(7'h7F));
    check("t6_cur_idx", 64'(bus.cur_idx), 64'd0);
    cycle("t6b");
    reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      randomize_inputs();
      cycle("rnd2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
